ysyx_24110015_axi4_mem_slave: RTL and testbench

//  AXI4 slave responder backed by an internal word-addressed RAM. It is the far end of the core's io_master AXI4

---
 rtl/ysyx_24110015_axi4_mem_slave.sv | 327 ++++++++++++++++++++++++++++++++
 tb/tb_ysyx_24110015_axi4_mem_slave.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24110015_axi4_mem_slave.sv
// ysyx_24110015_axi4_mem_slave
//   AXI4 slave backed by an internal word-addressed RAM of 2**DEPTH_LOG2 32-bit words
//   decoded at BASE_ADDR. The read and write channels run independent FSMs and support
//   FIXED/INCR/WRAP bursts of up to 16 beats.
//
//   Ports
//     clk_i, rst_ni                      clock, asynchronous active-low reset
//     aw*_i / awready_o                  write address channel (addr, id, len, size, burst)
//     w*_i  / wready_o                   write data channel (data, strb, last)
//     bvalid_o, bresp_o, bid_o / bready_i  write response channel
//     ar*_i / arready_o                  read address channel
//     rvalid_o, rdata_o, rresp_o, rlast_o, rid_o / rready_i  read data channel
//
//   Optional build macro AXI_MEM_SLAVE_RAND_DELAY_EN: a 16-bit LFSR (seed LFSR_SEED) adds
//   0-3 idle cycles before every ready/valid assertion. Without it, latency is fixed.
module ysyx_24110015_axi4_mem_slave #(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          DEPTH_LOG2 = 16,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        awvalid_i,
    output logic        awready_o,
    input  logic [31:0] awaddr_i,
    input  logic [3:0]  awid_i,
    input  logic [7:0]  awlen_i,
    input  logic [2:0]  awsize_i,
    input  logic [1:0]  awburst_i,
    input  logic        wvalid_i,
    output logic        wready_o,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    input  logic        wlast_i,
    output logic        bvalid_o,
    input  logic        bready_i,
    output logic [1:0]  bresp_o,
    output logic [3:0]  bid_o,
    input  logic        arvalid_i,
    output logic        arready_o,
    input  logic [31:0] araddr_i,
    input  logic [3:0]  arid_i,
    input  logic [7:0]  arlen_i,
    input  logic [2:0]  arsize_i,
    input  logic [1:0]  arburst_i,
    output logic        rvalid_o,
    input  logic        rready_i,
    output logic [31:0] rdata_o,
    output logic [1:0]  rresp_o,
    output logic        rlast_o,
    output logic [3:0]  rid_o
);

    localparam logic [31:0] SPAN = 32'd4 << DEPTH_LOG2;

    typedef enum logic       {R_IDLE, R_DATA} rstate_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;

    function automatic logic in_range(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return (a >= BASE_ADDR) && (off < SPAN);
    endfunction

    function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [31:0] a);
        return DEPTH_LOG2'((a - BASE_ADDR) >> 2);
    endfunction

    // WRAP relies on the window being a power of two; illegal lengths are flagged
    // SLVERR and the address pattern for them is don't-care.
    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [7:0] len,
                                              input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] step, mask;
        step = 32'd1 << size;
        mask = ((({24'd0, len}) + 32'd1) << size) - 32'd1;
        case (burst)
            2'b00:   return a;
            2'b10:   return (a & ~mask) | ((a + step) & mask);
            default: return a + step;
        endcase
    endfunction

    function automatic logic cfg_err(input logic [7:0] len, input logic [2:0] size,
                                     input logic [1:0] burst);
        return (size > 3'd2) || (burst == 2'b11) ||
               ((burst == 2'b10) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
    endfunction

    // Idle-cycle count applied before each ready/valid assertion.
    logic [1:0] dly_w;
`ifdef AXI_MEM_SLAVE_RAND_DELAY_EN
    logic [15:0] lfsr_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) lfsr_q <= LFSR_SEED;
        else         lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
    assign dly_w = lfsr_q[1:0];
`else
    logic [15:0] unused_seed;
    assign unused_seed = LFSR_SEED;
    assign dly_w       = 2'd0;
`endif

    logic [31:0] mem [2**DEPTH_LOG2];

    // ---------------- read channel ----------------
    rstate_e     rstate_q;
    logic        arready_q, rvalid_q, rlast_q;
    logic [31:0] rdata_q, raddr_q, raddr_d;
    logic [1:0]  rresp_q;
    logic [3:0]  rid_q;
    logic [7:0]  rlen_q, rbeat_q;
    logic [2:0]  rsize_q;
    logic [1:0]  rburst_q;
    logic [1:0]  rcnt_q;

    logic [31:0] rsrc_addr, rd_data_d;
    logic [7:0]  rsrc_len, rsrc_beat;
    logic [2:0]  rsrc_size;
    logic [1:0]  rsrc_burst, rd_resp_d;
    logic        rd_last_d;

    // The first beat is fetched straight from the AR inputs in the handshake cycle.
    always_comb begin
        if (rstate_q == R_IDLE) begin
            rsrc_addr  = araddr_i;
            rsrc_len   = arlen_i;
            rsrc_size  = arsize_i;
            rsrc_burst = arburst_i;
            rsrc_beat  = 8'd0;
        end else begin
            rsrc_addr  = raddr_q;
            rsrc_len   = rlen_q;
            rsrc_size  = rsize_q;
            rsrc_burst = rburst_q;
            rsrc_beat  = rbeat_q;
        end
        rd_data_d = in_range(rsrc_addr) ? mem[word_idx(rsrc_addr)] : 32'd0;
        rd_resp_d = !in_range(rsrc_addr)                    ? 2'b11 :
                    cfg_err(rsrc_len, rsrc_size, rsrc_burst) ? 2'b10 : 2'b00;
        rd_last_d = (rsrc_beat == rsrc_len);
        raddr_d   = next_addr(raddr_q, rlen_q, rsize_q, rburst_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            rid_q     <= '0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rbeat_q   <= '0;
            rsize_q   <= '0;
            rburst_q  <= '0;
            rcnt_q    <= '0;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    if (!arready_q) begin
                        if (rcnt_q == 2'd0) arready_q <= 1'b1;
                        else                rcnt_q    <= rcnt_q - 2'd1;
                    end else if (arvalid_i) begin
                        arready_q <= 1'b0;
                        raddr_q   <= araddr_i;
                        rid_q     <= arid_i;
                        rlen_q    <= arlen_i;
                        rsize_q   <= arsize_i;
                        rburst_q  <= arburst_i;
                        rbeat_q   <= 8'd0;
                        rstate_q  <= R_DATA;
                        if (dly_w == 2'd0) begin
                            rvalid_q <= 1'b1;
                            rdata_q  <= rd_data_d;
                            rresp_q  <= rd_resp_d;
                            rlast_q  <= rd_last_d;
                        end else begin
                            rcnt_q <= dly_w - 2'd1;
                        end
                    end
                end
                R_DATA: begin
                    if (rvalid_q) begin
                        if (rready_i) begin
                            rvalid_q <= 1'b0;
                            rlast_q  <= 1'b0;
                            if (rlast_q) begin
                                rstate_q <= R_IDLE;
                                if (dly_w == 2'd0) arready_q <= 1'b1;
                                else               rcnt_q    <= dly_w - 2'd1;
                            end else begin
                                // One mandatory gap cycle, plus any random delay.
                                raddr_q <= raddr_d;
                                rbeat_q <= rbeat_q + 8'd1;
                                rcnt_q  <= dly_w;
                            end
                        end
                    end else if (rcnt_q == 2'd0) begin
                        rvalid_q <= 1'b1;
                        rdata_q  <= rd_data_d;
                        rresp_q  <= rd_resp_d;
                        rlast_q  <= rd_last_d;
                    end else begin
                        rcnt_q <= rcnt_q - 2'd1;
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    // ---------------- write channel ----------------
    wstate_e     wstate_q;
    logic        awready_q, wready_q, bvalid_q;
    logic [1:0]  bresp_q;
    logic [3:0]  bid_q, wid_q;
    logic [31:0] waddr_q, waddr_d;
    logic [7:0]  wlen_q, wbeat_q;
    logic [2:0]  wsize_q;
    logic [1:0]  wburst_q;
    logic        werr_q, werr_d, wdec_q, wdec_d, wfire;
    logic [1:0]  wcnt_q;

    always_comb begin
        wfire   = wready_q && wvalid_i;
        waddr_d = next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
        werr_d  = werr_q | (wlast_i != (wbeat_q == wlen_q));
        wdec_d  = wdec_q | !in_range(waddr_q);
    end

    always_ff @(posedge clk_i) begin
        if (wfire && in_range(waddr_q)) begin
            for (int b = 0; b < 4; b++)
                if (wstrb_i[b]) mem[word_idx(waddr_q)][8*b +: 8] <= wdata_i[8*b +: 8];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            bid_q     <= '0;
            wid_q     <= '0;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wbeat_q   <= '0;
            wsize_q   <= '0;
            wburst_q  <= '0;
            werr_q    <= 1'b0;
            wdec_q    <= 1'b0;
            wcnt_q    <= '0;
        end else begin
            case (wstate_q)
                W_IDLE: begin
                    if (!awready_q) begin
                        if (wcnt_q == 2'd0) awready_q <= 1'b1;
                        else                wcnt_q    <= wcnt_q - 2'd1;
                    end else if (awvalid_i) begin
                        awready_q <= 1'b0;
                        waddr_q   <= awaddr_i;
                        wid_q     <= awid_i;
                        wlen_q    <= awlen_i;
                        wsize_q   <= awsize_i;
                        wburst_q  <= awburst_i;
                        wbeat_q   <= 8'd0;
                        werr_q    <= cfg_err(awlen_i, awsize_i, awburst_i);
                        wdec_q    <= 1'b0;
                        wstate_q  <= W_DATA;
                        if (dly_w == 2'd0) wready_q <= 1'b1;
                        else               wcnt_q   <= dly_w - 2'd1;
                    end
                end
                W_DATA: begin
                    if (!wready_q) begin
                        if (wcnt_q == 2'd0) wready_q <= 1'b1;
                        else                wcnt_q   <= wcnt_q - 2'd1;
                    end else if (wvalid_i) begin
                        waddr_q <= waddr_d;
                        wbeat_q <= wbeat_q + 8'd1;
                        werr_q  <= werr_d;
                        wdec_q  <= wdec_d;
                        // Burst length, not wlast, decides the end of the burst.
                        if (wbeat_q == wlen_q) begin
                            wready_q <= 1'b0;
                            wstate_q <= W_RESP;
                            bid_q    <= wid_q;
                            bresp_q  <= wdec_d ? 2'b11 : (werr_d ? 2'b10 : 2'b00);
                            if (dly_w == 2'd0) bvalid_q <= 1'b1;
                            else               wcnt_q   <= dly_w - 2'd1;
                        end
                    end
                end
                W_RESP: begin
                    if (!bvalid_q) begin
                        if (wcnt_q == 2'd0) bvalid_q <= 1'b1;
                        else                wcnt_q   <= wcnt_q - 2'd1;
                    end else if (bready_i) begin
                        bvalid_q <= 1'b0;
                        wstate_q <= W_IDLE;
                        if (dly_w == 2'd0) awready_q <= 1'b1;
                        else               wcnt_q    <= dly_w - 2'd1;
                    end
                end
                default: wstate_q <= W_IDLE;
            endcase
        end
    end

    assign arready_o = arready_q;
    assign rvalid_o  = rvalid_q;
    assign rdata_o   = rdata_q;
    assign rresp_o   = rresp_q;
    assign rlast_o   = rlast_q;
    assign rid_o     = rid_q;
    assign awready_o = awready_q;
    assign wready_o  = wready_q;
    assign bvalid_o  = bvalid_q;
    assign bresp_o   = bresp_q;
    assign bid_o     = bid_q;

endmodule

// File: tb/tb_ysyx_24110015_axi4_mem_slave.sv
// Directed bench for ysyx_24110015_axi4_mem_slave. A transaction-level model (word map,
// burst address arithmetic, response rules) queues expected R beats and B responses; a
// single monitor compares every R/B handshake against it and checks R stability under
// backpressure. Literal checks pin key results.
module tb_ysyx_24110015_axi4_mem_slave;

    logic        clk = 1'b0, rst_ni = 1'b1;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  awid, wstrb, bid, arid, rid;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;

    always #5 clk = ~clk;

    ysyx_24110015_axi4_mem_slave dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .awvalid_i(awvalid), .awready_o(awready), .awaddr_i(awaddr), .awid_i(awid),
        .awlen_i(awlen), .awsize_i(awsize), .awburst_i(awburst),
        .wvalid_i(wvalid), .wready_o(wready), .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast),
        .bvalid_o(bvalid), .bready_i(bready), .bresp_o(bresp), .bid_o(bid),
        .arvalid_i(arvalid), .arready_o(arready), .araddr_i(araddr), .arid_i(arid),
        .arlen_i(arlen), .arsize_i(arsize), .arburst_i(arburst),
        .rvalid_o(rvalid), .rready_i(rready), .rdata_o(rdata), .rresp_o(rresp),
        .rlast_o(rlast), .rid_o(rid)
    );

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: handshake never happened within the cycle budget", nm);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mdl [int unsigned];

    function automatic bit m_in(input logic [31:0] a);
        return (a >= 32'h8000_0000) && (a < 32'h8004_0000);
    endfunction

    function automatic int unsigned m_idx(input logic [31:0] a);
        return (a - 32'h8000_0000) / 4;
    endfunction

    function automatic logic [31:0] m_next(input logic [31:0] a, input int len, input int size,
                                           input int burst);
        longint unsigned bytes, win, base;
        bytes = longint'(1) << size;
        if (burst == 0) return a;
        if (burst == 2) begin
            win  = (len + 1) * bytes;
            base = (a / win) * win;
            return 32'(base + ((a - base + bytes) % win));
        end
        return 32'(a + bytes);
    endfunction

    function automatic bit m_cfg(input int len, input int size, input int burst);
        return size > 2 || burst == 3 ||
               (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
    endfunction

    typedef struct { logic [31:0] data; logic [1:0] resp; logic last; logic [3:0] id; } rexp_t;
    typedef struct { logic [1:0] resp; logic [3:0] id; } bexp_t;
    rexp_t exp_r[$];
    bexp_t exp_b[$];

    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic        wl [16];
    logic [31:0] cap [16];
    logic [1:0]  rr [16];
    logic [1:0]  last_bresp;

    function automatic logic rdy(input int ch);
        case (ch)
            0:       return awready;
            1:       return wready;
            default: return arready;
        endcase
    endfunction

    task automatic wait_ready(input int ch, input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (!rdy(ch) && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!rdy(ch)) tmo(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic set_wl(input int len);
        for (int i = 0; i < 16; i++) wl[i] = (i == len);
    endtask

    task automatic axi_write(input logic [31:0] addr, input int len, input int size,
                             input int burst, input logic [3:0] id);
        logic [31:0] a, w;
        bit dec, err;
        bexp_t e;
        int n;
        a = addr; dec = 0; err = m_cfg(len, size, burst);
        for (int i = 0; i <= len; i++) begin
            if (wl[i] != (i == len)) err = 1;
            if (!m_in(a)) dec = 1;
            else begin
                w = mdl.exists(m_idx(a)) ? mdl[m_idx(a)] : 32'd0;
                for (int b = 0; b < 4; b++)
                    if (ws[i][b]) w[8*b +: 8] = wd[i][8*b +: 8];
                mdl[m_idx(a)] = w;
            end
            a = m_next(a, len, size, burst);
        end
        e.resp = dec ? 2'b11 : (err ? 2'b10 : 2'b00);
        e.id   = id;
        exp_b.push_back(e);

        awaddr = addr; awlen = 8'(len); awsize = 3'(size); awburst = 2'(burst); awid = id;
        awvalid = 1'b1;
        wait_ready(0, "aw handshake");
        awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i]; wlast = wl[i];
            wait_ready(1, "w handshake");
        end
        wvalid = 1'b0; wlast = 1'b0;
        bready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bvalid && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!bvalid) tmo("b handshake");
        last_bresp = bresp;
        @(posedge clk);
        #1 bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input int len, input int size,
                            input int burst, input logic [3:0] id, input int stall_at);
        logic [31:0] a;
        rexp_t e;
        int got, n, stall_left;
        a = addr;
        for (int i = 0; i <= len; i++) begin
            e.data = (m_in(a) && mdl.exists(m_idx(a))) ? mdl[m_idx(a)] : 32'd0;
            e.resp = !m_in(a) ? 2'b11 : (m_cfg(len, size, burst) ? 2'b10 : 2'b00);
            e.last = (i == len);
            e.id   = id;
            exp_r.push_back(e);
            a = m_next(a, len, size, burst);
        end
        araddr = addr; arlen = 8'(len); arsize = 3'(size); arburst = 2'(burst); arid = id;
        arvalid = 1'b1;
        wait_ready(2, "ar handshake");
        arvalid = 1'b0;
        rready = 1'b1;
        got = 0; n = 0; stall_left = 6;
        while (got <= len && n < 400) begin
            @(negedge clk);
            n++;
            if (rvalid && rready) begin
                cap[got] = rdata;
                rr[got]  = rresp;
                got++;
            end
            @(posedge clk);
            #1;
            if (got == stall_at && stall_left > 0) begin
                rready = 1'b0;
                stall_left--;
            end else begin
                rready = 1'b1;
            end
        end
        rready = 1'b0;
        if (got <= len) tmo("r beats");
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic        pv, pl;
        logic [31:0] pd;
        logic [1:0]  pr;
        rexp_t       e;
        bexp_t       be;
        pv = 1'b0; pl = 1'b0; pd = '0; pr = '0;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                pv = 1'b0;
                continue;
            end
            if (pv) begin
                chk("r hold valid", rvalid, 1);
                chk("r hold data", rdata, pd);
                chk("r hold last", rlast, pl);
                chk("r hold resp", rresp, pr);
            end
            pv = rvalid && !rready; pd = rdata; pl = rlast; pr = rresp;
            if (rvalid && rready) begin
                if (exp_r.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL r extra beat: got data 0x%08h, want no beat", rdata);
                end else begin
                    e = exp_r.pop_front();
                    chk("r data", rdata, e.data);
                    chk("r resp", rresp, e.resp);
                    chk("r last", rlast, e.last);
                    chk("r id", rid, e.id);
                end
            end
            if (bvalid && bready) begin
                if (exp_b.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL b extra response: got resp %0d, want none", bresp);
                end else begin
                    be = exp_b.pop_front();
                    chk("b resp", bresp, be.resp);
                    chk("b id", bid, be.id);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awsize = 0; awburst = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
        arvalid = 0; araddr = 0; arid = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;
        for (int i = 0; i < 16; i++) begin wd[i] = 0; ws[i] = 4'hF; wl[i] = 0; end

        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst awready", awready, 1);
        chk("rst arready", arready, 1);
        chk("rst wready", wready, 0);
        chk("rst bvalid", bvalid, 0);
        chk("rst rvalid", rvalid, 0);
        chk("rst rlast", rlast, 0);
        chk("rst bresp", bresp, 0);
        chk("rst rresp", rresp, 0);
        chk("rst bid", bid, 0);
        chk("rst rid", rid, 0);
        chk("rst rdata", rdata, 0);
        @(posedge clk);
        #1 rst_ni = 1'b1;
        @(posedge clk);
        #1;

        // single word write / read
        wd[0] = 32'h1234_5678; set_wl(0);
        axi_write(32'h8000_0000, 0, 2, 1, 4'd3);
        chk("t1 bresp", last_bresp, 2'b00);
        axi_read(32'h8000_0000, 0, 2, 1, 4'd5, 99);
        chk("t1 rdata", cap[0], 32'h1234_5678);

        // INCR burst of four
        for (int i = 0; i < 4; i++) wd[i] = 32'(i + 1);
        set_wl(3);
        axi_write(32'h8000_0010, 3, 2, 1, 4'd1);
        axi_read(32'h8000_0010, 3, 2, 1, 4'd2, 99);
        for (int i = 0; i < 4; i++) chk("t2 incr beat", cap[i], 32'(i + 1));

        // byte-lane write into word 0
        wd[0] = 32'h00AB_0000; ws[0] = 4'b0100; set_wl(0);
        axi_write(32'h8000_0002, 0, 2, 1, 4'd4);
        ws[0] = 4'hF;
        axi_read(32'h8000_0000, 0, 2, 1, 4'd6, 99);
        chk("t3 byte merge", cap[0], 32'h12AB_5678);

        // decode boundaries
        wd[0] = 32'h5A5A_5A5A;
        axi_write(32'h8003_FFFC, 0, 2, 1, 4'd7);
        chk("t4 last word bresp", last_bresp, 2'b00);
        axi_read(32'h7FFF_FFFC, 0, 2, 1, 4'd8, 99);
        chk("t4 below rdata", cap[0], 0);
        chk("t4 below rresp", rr[0], 2'b11);
        wd[0] = 32'hDEAD_BEEF;
        axi_write(32'h7FFF_FFFC, 0, 2, 1, 4'd9);
        chk("t4 below bresp", last_bresp, 2'b11);
        axi_read(32'h8003_FFFC, 0, 2, 1, 4'd10, 99);
        chk("t4 ram untouched", cap[0], 32'h5A5A_5A5A);
        axi_read(32'h8004_0000, 0, 2, 1, 4'd11, 99);
        chk("t4 above rresp", rr[0], 2'b11);

        // WRAP read, protocol errors, FIXED burst
        axi_read(32'h8000_0018, 3, 2, 2, 4'd12, 99);
        chk("t5 wrap 0", cap[0], 32'd3);
        chk("t5 wrap 1", cap[1], 32'd4);
        chk("t5 wrap 2", cap[2], 32'd1);
        chk("t5 wrap 3", cap[3], 32'd2);
        wd[0] = 32'h11; wd[1] = 32'h22; set_wl(0);
        axi_write(32'h8000_0020, 1, 2, 1, 4'd13);
        chk("t5 wlast early bresp", last_bresp, 2'b10);
        axi_read(32'h8000_0020, 1, 2, 1, 4'd14, 99);
        set_wl(2);
        axi_write(32'h8000_0100, 2, 2, 2, 4'd15);
        chk("t5 wrap len2 bresp", last_bresp, 2'b10);
        axi_read(32'h8000_0000, 0, 3, 1, 4'd1, 99);
        chk("t5 size3 rresp", rr[0], 2'b10);
        wd[0] = 32'hA; wd[1] = 32'hB; set_wl(1);
        axi_write(32'h8000_0030, 1, 2, 0, 4'd2);
        chk("t5 fixed bresp", last_bresp, 2'b00);
        axi_read(32'h8000_0030, 0, 2, 1, 4'd3, 99);
        chk("t5 fixed last wins", cap[0], 32'hB);

        // backpressure mid-burst
        axi_read(32'h8000_0010, 3, 2, 1, 4'd7, 2);
        chk("t6 stalled beat", cap[2], 32'd3);

        // reset in the middle of a read burst
        araddr = 32'h8000_0010; arlen = 8'd3; arsize = 3'd2; arburst = 2'd1; arid = 4'd9;
        begin
            rexp_t e;
            e.data = 32'd1; e.resp = 2'b00; e.last = 1'b0; e.id = 4'd9;
            exp_r.push_back(e);
        end
        arvalid = 1'b1;
        wait_ready(2, "t6 ar handshake");
        arvalid = 1'b0;
        rready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rvalid && n < 50) begin n++; @(negedge clk); end
        if (!rvalid) tmo("t6 first beat");
        @(posedge clk);
        #1 rready = 1'b0;
        n = 0;
        @(negedge clk);
        while (!rvalid && n < 50) begin n++; @(negedge clk); end
        if (!rvalid) tmo("t6 second beat");
        #1 rst_ni = 1'b0;
        #1;
        chk("t6 rst rvalid", rvalid, 0);
        chk("t6 rst arready", arready, 1);
        chk("t6 rst rlast", rlast, 0);
        exp_r.delete();
        @(posedge clk);
        @(posedge clk);
        #1 rst_ni = 1'b1;
        @(negedge clk);
        chk("t6 post arready", arready, 1);
        chk("t6 post rvalid", rvalid, 0);
        @(posedge clk);
        #1;
        axi_read(32'h8000_0000, 0, 2, 1, 4'd4, 99);
        chk("t6 ram kept", cap[0], 32'h12AB_5678);

        repeat (3) @(posedge clk);
        chk("r queue drained", exp_r.size(), 0);
        chk("b queue drained", exp_b.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
